// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU sequencer.
//   ALU command codes (AD..DV1), operation-class codes, sequencer state
//   encoding, +0/-0 ones-complement constants and command-selection helpers.
package alu_pkg;

    localparam int unsigned DATA_W = 16;  // operand word: [15:1] data, [0] parity
    localparam int unsigned RES_W  = 15;  // ALU result word
    localparam int unsigned OP_W   = 3;
    localparam int unsigned CMD_W  = 3;

    typedef enum logic [CMD_W-1:0] {
        CMD_AD   = 3'd0,
        CMD_SU   = 3'd1,
        CMD_MASK = 3'd2,
        CMD_MP0  = 3'd3,
        CMD_MP1  = 3'd4,
        CMD_DV0  = 3'd5,
        CMD_DV1  = 3'd6
    } alu_cmd_e;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MASK = 3'd2,
        OP_MPY  = 3'd3,
        OP_DIV  = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PH0  = 2'd1,
        ST_PH1  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    localparam logic [RES_W-1:0] POS_ZERO = 15'h0000;
    localparam logic [RES_W-1:0] NEG_ZERO = 15'h7FFF;

    // First-phase ALU command for a legal operation class.
    function automatic logic [CMD_W-1:0] ph0_cmd(input logic [OP_W-1:0] op);
        case (op)
            OP_SUB:  return CMD_SU;
            OP_MASK: return CMD_MASK;
            OP_MPY:  return CMD_MP0;
            OP_DIV:  return CMD_DV0;
            default: return CMD_AD;
        endcase
    endfunction

    // Second-phase ALU command; only MPY and DIV have one.
    function automatic logic [CMD_W-1:0] ph1_cmd(input logic [OP_W-1:0] op);
        return (op == OP_MPY) ? CMD_MP1 : CMD_DV1;
    endfunction

endpackage

// File: rtl/odd_parity16.sv
// odd_parity16: combinational odd-parity checker over a 16-bit word.
//   data  in  16  word to check
//   ok_c  out 1   high when the word has an odd number of ones
// Built only when ALU_SEQ_PARITY_EN is defined.
`ifdef ALU_SEQ_PARITY_EN
module odd_parity16
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic              ok_c
);

    assign ok_c = ^data;

endmodule
`endif

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one arithmetic request at a time, checks operands,
// drives the ones-complement ALU through one (AD/SU/MASK) or two (MP0/MP1,
// DV0/DV1) phases of ALU_LAT cycles each and captures the result pair.
//   clk, reset            clock, synchronous active-high reset
//   req, op, opnd_a/b     request strobe, op class, operands ([0] = parity)
//   ack, busy, done       accept pulse, in-progress level, completion pulse
//   res_hi, res_lo        captured results, held until the next ack
//   parity_err, div_zero, illegal_op   error flags, valid with done
//   alu_a, alu_b, alu_cmd, alu_res     ALU operand/command/result ports
// Optional: ALU_SEQ_PARITY_EN enables odd-parity checking of both operands.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] opnd_a,
    input  logic [DATA_W-1:0] opnd_b,
    output logic              ack,
    output logic              busy,
    output logic              done,
    output logic [RES_W-1:0]  res_hi,
    output logic [RES_W-1:0]  res_lo,
    output logic              parity_err,
    output logic              div_zero,
    output logic              illegal_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CMD_W-1:0]  alu_cmd,
    input  logic [RES_W-1:0]  alu_res
);

    localparam int unsigned      CNT_W    = 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ALU_LAT - 1);

    state_e             state, state_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               ack_d, busy_d, done_d;
    logic               parity_err_d, div_zero_d, illegal_op_d;
    logic [RES_W-1:0]   res_hi_d, res_lo_d;
    logic [DATA_W-1:0]  alu_a_d, alu_b_d;
    logic [CMD_W-1:0]   alu_cmd_d;
    logic               parity_fail_c;
    logic               seq_end;

    // Operand parity check (odd parity over all 16 bits of each operand).
`ifdef ALU_SEQ_PARITY_EN
    logic a_ok_c, b_ok_c;
    odd_parity16 u_par_a (.data(opnd_a), .ok_c(a_ok_c));
    odd_parity16 u_par_b (.data(opnd_b), .ok_c(b_ok_c));
    assign parity_fail_c = !(a_ok_c && b_ok_c);
`else
    assign parity_fail_c = 1'b0;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state;
        op_d         = op_q;
        cnt_d        = cnt;
        ack_d        = 1'b0;
        busy_d       = (state != ST_IDLE);
        done_d       = 1'b0;
        parity_err_d = parity_err;
        div_zero_d   = div_zero;
        illegal_op_d = illegal_op;
        res_hi_d     = res_hi;
        res_lo_d     = res_lo;
        alu_a_d      = alu_a;
        alu_b_d      = alu_b;
        alu_cmd_d    = alu_cmd;
        seq_end      = 1'b0;

        unique case (state)
            ST_IDLE: begin
                alu_cmd_d = CMD_AD;
                alu_a_d   = '0;
                alu_b_d   = '0;
                if (req) begin
                    ack_d        = 1'b1;
                    busy_d       = 1'b1;
                    op_d         = op;
                    cnt_d        = '0;
                    parity_err_d = 1'b0;
                    div_zero_d   = 1'b0;
                    illegal_op_d = 1'b0;
                    if (op > OP_DIV) begin
                        illegal_op_d = 1'b1;
                        state_d      = ST_FIN;
                    end else if (parity_fail_c) begin
                        parity_err_d = 1'b1;
                        state_d      = ST_FIN;
                    end else if (op == OP_DIV &&
                                 (opnd_b[15:1] == POS_ZERO || opnd_b[15:1] == NEG_ZERO)) begin
                        div_zero_d = 1'b1;
                        state_d    = ST_FIN;
                    end else begin
                        state_d   = ST_PH0;
                        alu_cmd_d = ph0_cmd(op);
                        alu_a_d   = opnd_a;
                        alu_b_d   = opnd_b;
                    end
                end
            end
            ST_PH0: begin
                if (cnt == LAST_CNT) begin
                    res_hi_d = alu_res;
                    cnt_d    = '0;
                    if (op_q == OP_MPY || op_q == OP_DIV) begin
                        state_d   = ST_PH1;
                        alu_cmd_d = ph1_cmd(op_q);
                    end else begin
                        res_lo_d = '0;
                        seq_end  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_PH1: begin
                if (cnt == LAST_CNT) begin
                    res_lo_d = alu_res;
                    seq_end  = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_FIN: seq_end = 1'b1;
            default: state_d = ST_IDLE;
        endcase

        // Completion lands in IDLE so a held req is re-sampled on the edge ending done.
        if (seq_end) begin
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            busy_d    = 1'b1;
            alu_cmd_d = CMD_AD;
            alu_a_d   = '0;
            alu_b_d   = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            cnt        <= '0;
            ack        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            parity_err <= 1'b0;
            div_zero   <= 1'b0;
            illegal_op <= 1'b0;
            res_hi     <= '0;
            res_lo     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cmd    <= CMD_AD;
        end else begin
            state      <= state_d;
            op_q       <= op_d;
            cnt        <= cnt_d;
            ack        <= ack_d;
            busy       <= busy_d;
            done       <= done_d;
            parity_err <= parity_err_d;
            div_zero   <= div_zero_d;
            illegal_op <= illegal_op_d;
            res_hi     <= res_hi_d;
            res_lo     <= res_lo_d;
            alu_a      <= alu_a_d;
            alu_b      <= alu_b_d;
            alu_cmd    <= alu_cmd_d;
        end
    end

endmodule
